// File: rtl/adc_buf_stats_pkg.sv
// Shared types for the ADC buffer statistics engine: default widths, sample/address
// types and the sweep FSM state encoding.
package adc_buf_stats_pkg;

  localparam int unsigned DefDwidth = 16;
  localparam int unsigned DefAwidth = 16;

  typedef logic signed [DefDwidth-1:0] sample_t;
  typedef logic        [DefAwidth-1:0] addr_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/adc_stats_acc.sv
// Sample accumulator: delays the read-valid/index by the DPBRAM latency and keeps
// running sum, extremes and their first-occurrence indices. Outputs are next-state values.
module adc_stats_acc
  import adc_buf_stats_pkg::*;
#(
  parameter int unsigned DWIDTH = DefDwidth,
  parameter int unsigned AWIDTH = DefAwidth,
  parameter int unsigned SUM_W  = DWIDTH + AWIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_init,
  input  logic                     i_valid,
  input  logic signed [DWIDTH-1:0] i_data,
  input  logic        [AWIDTH-1:0] i_idx,
  output logic        [SUM_W-1:0]  o_sum,
  output logic        [DWIDTH-1:0] o_min,
  output logic        [DWIDTH-1:0] o_max,
  output logic        [AWIDTH-1:0] o_min_idx,
  output logic        [AWIDTH-1:0] o_max_idx,
  output logic        [AWIDTH-1:0] o_count
);

  logic                     valid_q, init_q;
  logic        [AWIDTH-1:0] idx_q;
  logic signed [SUM_W-1:0]  sum_q, sum_d, data_ext;
  logic signed [DWIDTH-1:0] min_q, min_d, max_q, max_d;
  logic        [AWIDTH-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
  logic        [AWIDTH-1:0] count_q, count_d;

  assign data_ext = {{(SUM_W-DWIDTH){i_data[DWIDTH-1]}}, i_data};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      init_q    <= 1'b0;
      idx_q     <= '0;
      sum_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= i_valid;
      init_q    <= i_init;
      idx_q     <= i_idx;
      sum_q     <= sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      count_q   <= count_d;
    end
  end

  // Strict compares keep the earliest index on ties.
  always_comb begin
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    count_d   = count_q;
    if (valid_q) begin
      if (init_q) begin
        sum_d     = data_ext;
        min_d     = i_data;
        max_d     = i_data;
        min_idx_d = idx_q;
        max_idx_d = idx_q;
        count_d   = AWIDTH'(1);
      end else begin
        sum_d   = sum_q + data_ext;
        count_d = count_q + AWIDTH'(1);
        if (i_data < min_q) begin
          min_d     = i_data;
          min_idx_d = idx_q;
        end
        if (i_data > max_q) begin
          max_d     = i_data;
          max_idx_d = idx_q;
        end
      end
    end
  end

  assign o_sum     = sum_d;
  assign o_min     = min_d;
  assign o_max     = max_d;
  assign o_min_idx = min_idx_d;
  assign o_max_idx = max_idx_d;
  assign o_count   = count_d;

endmodule

// File: rtl/adc_buf_stats.sv
// Post-capture statistics sweep over the ADC sample DPBRAM: sequences reads, then
// latches sum/min/max/indices/count into result registers when the sweep completes.
module adc_buf_stats
  import adc_buf_stats_pkg::*;
#(
  parameter int unsigned DWIDTH   = DefDwidth,
  parameter int unsigned AWIDTH   = DefAwidth,
  parameter int unsigned MEM_SIZE = 10000,
  parameter int unsigned SUM_W    = DWIDTH + AWIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [AWIDTH-1:0] i_len,
  output logic [AWIDTH-1:0] o_ram_addr,
  output logic              o_ram_ce,
  input  logic [DWIDTH-1:0] i_ram_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [SUM_W-1:0]  o_sum,
  output logic [DWIDTH-1:0] o_min,
  output logic [DWIDTH-1:0] o_max,
  output logic [AWIDTH-1:0] o_min_idx,
  output logic [AWIDTH-1:0] o_max_idx,
  output logic [AWIDTH-1:0] o_count
);

  // One extra bit so a record of exactly 2^AWIDTH samples is representable.
  localparam int unsigned LenW = AWIDTH + 1;
  localparam logic [AWIDTH:0] MemSizeW = LenW'(MEM_SIZE);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d, last_q, last_d;
  logic [AWIDTH:0]   len_clamp;
  logic              load_res, zero_res, acc_init;

  logic [SUM_W-1:0]  acc_sum, res_sum_q;
  logic [DWIDTH-1:0] acc_min, acc_max, res_min_q, res_max_q;
  logic [AWIDTH-1:0] acc_min_idx, acc_max_idx, acc_count;
  logic [AWIDTH-1:0] res_min_idx_q, res_max_idx_q, res_count_q;

  assign len_clamp = ({1'b0, i_len} > MemSizeW) ? MemSizeW : {1'b0, i_len};
  assign acc_init  = o_ram_ce && (addr_q == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    o_ram_ce = 1'b0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    load_res = 1'b0;
    zero_res = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // A new start is accepted in the done cycle too.
        o_done  = (state_q == StDone);
        state_d = StIdle;
        if (i_start) begin
          addr_d = '0;
          last_d = AWIDTH'(len_clamp - LenW'(1));
          if (len_clamp == '0) begin
            state_d  = StDone;
            zero_res = 1'b1;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        o_busy   = 1'b1;
        o_ram_ce = 1'b1;
        if (i_abort) begin
          state_d = StIdle;
        end else if (addr_q == last_q) begin
          state_d = StDrain;
        end else begin
          addr_d = addr_q + AWIDTH'(1);
        end
      end
      StDrain: begin
        o_busy = 1'b1;
        if (i_abort) begin
          state_d = StIdle;
        end else begin
          state_d  = StDone;
          load_res = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  adc_stats_acc #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH),
    .SUM_W (SUM_W)
  ) u_acc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_init   (acc_init),
    .i_valid  (o_ram_ce),
    .i_data   (i_ram_data),
    .i_idx    (addr_q),
    .o_sum    (acc_sum),
    .o_min    (acc_min),
    .o_max    (acc_max),
    .o_min_idx(acc_min_idx),
    .o_max_idx(acc_max_idx),
    .o_count  (acc_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      res_sum_q     <= '0;
      res_min_q     <= '0;
      res_max_q     <= '0;
      res_min_idx_q <= '0;
      res_max_idx_q <= '0;
      res_count_q   <= '0;
    end else if (zero_res) begin
      res_sum_q     <= '0;
      res_min_q     <= '0;
      res_max_q     <= '0;
      res_min_idx_q <= '0;
      res_max_idx_q <= '0;
      res_count_q   <= '0;
    end else if (load_res) begin
      res_sum_q     <= acc_sum;
      res_min_q     <= acc_min;
      res_max_q     <= acc_max;
      res_min_idx_q <= acc_min_idx;
      res_max_idx_q <= acc_max_idx;
      res_count_q   <= acc_count;
    end
  end

  assign o_ram_addr = addr_q;
  assign o_sum      = res_sum_q;
  assign o_min      = res_min_q;
  assign o_max      = res_max_q;
  assign o_min_idx  = res_min_idx_q;
  assign o_max_idx  = res_max_idx_q;
  assign o_count    = res_count_q;

endmodule

// File: doc/adc_buf_stats.md
# adc_buf_stats

Post-capture statistics engine that sits directly downstream of the AD7903 capture path. After a capture completes, it sweeps the ADC sample DPBRAM through a spare read port and produces sum, minimum, maximum and the index of each extreme over the captured record. Results are held in registers for the AXI register file, so software does not have to read every sample word.

## Interface
Parameters:
- DWIDTH, 16: sample width; samples are two's-complement.
- AWIDTH, 16: DPBRAM address width.
- MEM_SIZE, 10000: DPBRAM depth; upper limit for the record length.
- SUM_W, DWIDTH+AWIDTH: accumulator width, signed.

Ports:
- i_clk  in  1  system clock, 200 MHz.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle request to begin a sweep; the integrator drives it from the capture-complete flag edge.
- i_abort  in  1  cancels a running sweep.
- i_len  in  AWIDTH  number of samples to process; sampled on the accepted i_start.
- o_ram_addr  out  AWIDTH  DPBRAM read address.
- o_ram_ce  out  1  DPBRAM read enable.
- i_ram_data  in  DWIDTH  DPBRAM read data; valid 1 cycle after an address is presented with ce.
- o_busy  out  1  high while a sweep is in progress.
- o_done  out  1  one-cycle pulse when a sweep completes.
- o_sum  out  SUM_W  signed sum of the samples.
- o_min, o_max  out  DWIDTH  signed extremes.
- o_min_idx, o_max_idx  out  AWIDTH  address of the first occurrence of each extreme.
- o_count  out  AWIDTH  number of samples actually processed.

## Operation
- FSM states:
  - IDLE: waits for i_start.
  - READ: issues addresses.
  - DRAIN: one cycle, takes in the last sample.
  - DONE: one cycle, raises o_done and returns to IDLE.
- In IDLE, i_start=1:
  - latch len = min(i_len, MEM_SIZE);
  - if len=0, go to DONE with sum=0, min=max=0, idx=0, count=0;
  - otherwise go to READ with addr=0.
- READ:
  - o_ram_ce=1 and o_ram_addr=k for k=0..len-1, one address per cycle.
  - After issuing len-1, go to DRAIN.
- Data pipeline:
  - A valid flag is delayed 1 cycle from ce, and the address is delayed alongside it as the sample index.
  - The first valid sample initialises sum, min, max and both indices.
  - Each later valid sample adds to sum (sign-extended).
  - min/max update only on a strictly smaller/larger value, so ties keep the earlier index.
- Results registers update only at the transition into DONE. They hold the previous results during a sweep and until the next completed sweep. Internal accumulators are separate from the output registers.
- i_start while busy: ignored.
- i_abort in READ/DRAIN: return to IDLE next cycle, no o_done, results unchanged. i_abort in IDLE or DONE: no effect.
- i_start and i_abort in the same cycle in IDLE: start wins.
- Address arithmetic never wraps, because len ≤ MEM_SIZE ≤ 2^AWIDTH.

## Timing
- Reset values: all outputs 0; state IDLE.
- i_start accepted at clock edge t0:
  - o_busy=1 and address 0 are driven from t0+1;
  - address k is driven in cycle t0+1+k;
  - its data is accumulated at edge t0+2+k;
  - o_done=1 and the new results are visible in cycle t0+len+2.
- Total latency: len+2 cycles from the start edge to o_done. For len=0, o_done is at t0+1.
- o_busy falls in the same cycle that o_done rises, so a new i_start is accepted in the o_done cycle.
- i_rst asserted mid-sweep: immediate return to reset values, including the results registers.

## Structure
- Shared package: sample type (signed DWIDTH), address type, and the FSM state enum {IDLE, READ, DRAIN, DONE}.
- Natural sub-module: adc_stats_acc. It holds the valid/index delay stage plus the sum/min/max/index registers, with inputs init, valid, data and idx.
- The top level holds the FSM, the address counter and the length clamp.

## Test plan
- Memory preloaded with samples 0..9, i_len=10 -> o_sum=45, o_min=0 at idx 0, o_max=9 at idx 9, o_count=10, o_done at t0+12.
- Samples {5, -3, 7, -3, 7}, len=5 -> sum=13, min=-3 at idx 1, max=7 at idx 2 (ties keep the first index).
- i_len=0 -> o_done at t0+1, all results 0, o_ram_ce never asserted.
- i_len=MEM_SIZE+100 with all samples 0x8000 -> count=10000, sum=-327680000 with no overflow, last address issued 9999.
- Abort 4 cycles into a len=100 sweep -> no o_done, previous results held. A second i_start issued while busy is ignored.
- i_rst pulsed mid-sweep -> all outputs 0 on the next cycle. A fresh sweep afterwards produces the correct results.
